// File: rtl/reconvolute.sv
// Reconvolution stage: re-applies the exponential PMT tail, x[n] = RN*d[n] + FD*x[n-1].
// One sample per ENABLE40; a 3-state sequencer time-shares a single multiplier.
module reconvolute #(
    parameter int DW       = 12,
    parameter int FD_BITS  = 6,
    parameter int RN_BITS  = 6,
    parameter int RN_FRAC  = 4,
    parameter int ACC_INT  = 14,
    parameter int ACC_FRAC = 6
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               ENABLE40,
    input  logic               CLR,
    input  logic [DW-1:0]      DIN,
    input  logic [FD_BITS-1:0] FD,
    input  logic [RN_BITS-1:0] RN,
    output logic [DW-1:0]      DOUT,
    output logic               DOUT_VALID,
    output logic               OVERRUN
);

    localparam int AW = ACC_INT + ACC_FRAC;
    localparam int SW = DW + RN_BITS;
    localparam int BW = (FD_BITS > RN_BITS) ? FD_BITS : RN_BITS;
    localparam int MW = AW + BW;
    localparam int QW = AW - ACC_FRAC + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ADD
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [AW-1:0]        r_acc;
    logic [SW-1:0]        r_scaled;
    logic [AW-1:0]        r_decay;
    logic [FD_BITS-1:0]   r_fd;
    logic                 r_pend;
    logic [DW-1:0]        r_dout;
    logic                 r_valid;
    logic                 r_ovr;

    logic                 w_idle;
    logic                 w_accept;
    logic [AW-1:0]        w_mul_a;
    logic [BW-1:0]        w_mul_b;
    logic [MW-1:0]        w_prod;
    logic [AW:0]          w_sum;
    logic [AW-1:0]        w_acc_sat;
    logic [AW:0]          w_rnd;
    logic [QW-1:0]        w_q;
    logic [DW-1:0]        w_dout;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && ENABLE40 && !CLR;

    // IDLE multiplies DIN*RN, MUL multiplies ACC*FD on the same hardware
    assign w_mul_a = w_idle ? AW'(DIN) : r_acc;
    assign w_mul_b = w_idle ? BW'(RN) : BW'(r_fd);
    assign w_prod  = MW'(w_mul_a) * MW'(w_mul_b);

    assign w_sum = (AW+1)'(r_decay)
                 + ((AW+1)'(r_scaled) << (ACC_FRAC - RN_FRAC));
    assign w_acc_sat = w_sum[AW] ? {AW{1'b1}} : w_sum[AW-1:0];

    assign w_rnd  = (AW+1)'(r_acc) + (AW+1)'(1 << (ACC_FRAC - 1));
    assign w_q    = w_rnd[AW:ACC_FRAC];
    assign w_dout = (|w_q[QW-1:DW]) ? {DW{1'b1}} : w_q[DW-1:0];

    always_comb begin
        w_next = r_state;
        if (CLR) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (ENABLE40) w_next = S_MUL;
                S_MUL:   w_next = S_ADD;
                S_ADD:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_acc    <= '0;
            r_scaled <= '0;
            r_decay  <= '0;
            r_fd     <= '0;
            r_pend   <= 1'b0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else if (CLR) begin
            r_acc   <= '0;
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_scaled <= w_prod[SW-1:0];
                r_fd     <= FD;
            end
            if (r_state == S_MUL) begin
                r_decay <= w_prod[AW+FD_BITS-1:FD_BITS];
            end
            if (r_state == S_ADD) begin
                r_acc <= w_acc_sat;
            end
            r_pend <= (r_state == S_ADD);
            if (r_pend) begin
                r_dout  <= w_dout;
                r_valid <= 1'b1;
            end
            if (ENABLE40 && !w_idle) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign DOUT       = r_dout;
    assign DOUT_VALID = r_valid;
    assign OVERRUN    = r_ovr;

endmodule

// File: tb/tb_reconvolute.sv
// Scoreboard bench for reconvolute: stimulus queues expected DOUT values,
// a negedge monitor pops one per DOUT_VALID pulse.
module tb_reconvolute;

    logic        CLK;
    logic        RST_N;
    logic        ENABLE40;
    logic        CLR;
    logic [11:0] DIN;
    logic [5:0]  FD;
    logic [5:0]  RN;
    logic [11:0] DOUT;
    logic        DOUT_VALID;
    logic        OVERRUN;

    int total = 0;
    int bad   = 0;
    int expq[$];
    longint macc;

    reconvolute dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ENABLE40   (ENABLE40),
        .CLR        (CLR),
        .DIN        (DIN),
        .FD         (FD),
        .RN         (RN),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .OVERRUN    (OVERRUN)
    );

    initial CLK = 1'b0;
    always #4 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST_N && DOUT_VALID) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid dout=%0d required=none", DOUT);
            end else begin
                int e;
                e = expq.pop_front();
                if (int'(DOUT) != e) begin
                    bad++;
                    $display("FAIL dout got=%0d required=%0d", DOUT, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input int din, input int fd, input int rn, input int exp);
        expq.push_back(exp);
        DIN = 12'(din);
        FD = 6'(fd);
        RN = 6'(rn);
        ENABLE40 = 1'b1;
        tick();
        ENABLE40 = 1'b0;
        tick();
        tick();
    endtask

    task automatic clr();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        tick();
        macc = 0;
    endtask

    function automatic int model(input int din, input int fd, input int rn);
        longint d;
        longint q;
        d = ((macc * fd) >> 6) + longint'(din) * rn * 4;
        macc = (d > 1048575) ? 1048575 : d;
        q = (macc + 32) >> 6;
        return (q > 4095) ? 4095 : int'(q);
    endfunction

    initial begin
        RST_N = 1'b0;
        ENABLE40 = 1'b0;
        CLR = 1'b0;
        DIN = '0;
        FD = '0;
        RN = '0;
        macc = 0;
        #20;
        chk("reset_dout", int'(DOUT), 0);
        chk("reset_valid", int'(DOUT_VALID), 0);
        chk("reset_overrun", int'(OVERRUN), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // identity with explicit latency and single-pulse checks
        expq.push_back(100);
        DIN = 12'd100;
        FD = 6'd0;
        RN = 6'h10;
        ENABLE40 = 1'b1;
        tick();
        ENABLE40 = 1'b0;
        tick();
        tick();
        chk("id_valid_early", int'(DOUT_VALID), 0);
        tick();
        chk("id_valid_t3", int'(DOUT_VALID), 1);
        chk("id_dout", int'(DOUT), 100);
        tick();
        chk("id_single_pulse", int'(DOUT_VALID), 0);
        tick();

        // impulse decay, FD = 0.5
        clr();
        sample(1000, 32, 16, 1000);
        sample(0, 32, 16, 500);
        sample(0, 32, 16, 250);
        sample(0, 32, 16, 125);
        sample(0, 32, 16, 63);
        sample(0, 32, 16, 31);
        tick();

        // steady state, FD = 0.75, DIN = 25 -> 100
        clr();
        for (int i = 0; i < 40; i++) begin
            sample(25, 48, 16, model(25, 48, 16));
        end
        tick();
        chk("steady_dout", int'(DOUT), 100);

        // saturation, then FD = 1/64 decay shows ACC held all-ones
        clr();
        for (int i = 0; i < 6; i++) begin
            sample(4095, 63, 63, model(4095, 63, 63));
        end
        tick();
        chk("sat_dout", int'(DOUT), 4095);
        sample(0, 1, 16, model(0, 1, 16));
        tick();
        chk("sat_no_wrap", int'(DOUT), 256);

        // overrun then clear
        clr();
        sample(50, 0, 16, 50);
        expq.push_back(60);
        DIN = 12'd60;
        FD = 6'd0;
        RN = 6'h10;
        ENABLE40 = 1'b1;
        tick();
        DIN = 12'd99;
        tick();
        ENABLE40 = 1'b0;
        repeat (3) tick();
        chk("overrun_set", int'(OVERRUN), 1);
        chk("overrun_dout", int'(DOUT), 60);
        clr();
        chk("overrun_clr", int'(OVERRUN), 0);
        chk("clr_dout_hold", int'(DOUT), 60);
        sample(7, 32, 16, 7);
        tick();

        // CLR drops an in-flight sample
        DIN = 12'd200;
        FD = 6'd0;
        RN = 6'h10;
        ENABLE40 = 1'b1;
        tick();
        ENABLE40 = 1'b0;
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        repeat (4) tick();
        chk("clr_drop_dout", int'(DOUT), 7);

        // reset during MUL
        expq.push_back(40);
        DIN = 12'd40;
        ENABLE40 = 1'b1;
        tick();
        tick();
        ENABLE40 = 1'b0;
        repeat (3) tick();
        chk("pre_rst_overrun", int'(OVERRUN), 1);
        chk("pre_rst_dout", int'(DOUT), 40);
        DIN = 12'd80;
        ENABLE40 = 1'b1;
        tick();
        ENABLE40 = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("rst_dout", int'(DOUT), 0);
        chk("rst_valid", int'(DOUT_VALID), 0);
        chk("rst_overrun", int'(OVERRUN), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) tick();

        chk("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
